// File: rtl/fold_pkg.sv
// Shared types and widths for the fold register sequencer.
package fold_pkg;

  localparam int FOLD_W = 15;
  localparam int CNT_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } fold_state_t;

endpackage

// File: rtl/fold_seq_popcnt15.sv
// Combinational 15-bit population count used for the result weight flag.
module popcnt15 (
  input  logic [14:0] din,
  output logic [3:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 15; i++) begin
      cnt = cnt + 4'(din[i]);
    end
  end

endmodule

// File: rtl/fold_seq.sv
// Sequencer/result stage for the 15-bit fold register: clear, shift N+K, capture.
// Optional popcount weight flag enabled by defining FOLD_SEQ_WEIGHT_EN.
module fold_seq
  import fold_pkg::*;
#(
  parameter int N = 64,
  parameter int K = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_data,
  output logic [N-1:0]        fold_data_in,
  output logic                fold_clr,
  output logic                fold_shift,
  input  logic [CNT_W-1:0]    fold_count,
  input  logic [FOLD_W-1:0]   fold_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FOLD_W-1:0]   out_result,
  output logic                out_zero,
  output logic [3:0]          out_weight
);

  localparam logic [11:0] NK = 12'(N + K);

  fold_state_t state, state_nx;
  logic [11:0] cnt_ext;
  logic        cnt_done;
  logic        accept;
  logic        capture;

  function automatic logic is_zero(input logic [FOLD_W-1:0] v);
    return (v == '0);
  endfunction

  assign cnt_ext  = {1'b0, fold_count};
  // A count past N+K counts as complete so a misbehaving register cannot hang us.
  assign cnt_done = (cnt_ext >= NK);
  assign accept   = (state == IDLE) && in_valid;
  assign capture  = (state == SHIFT) && cnt_done;

`ifdef FOLD_SEQ_WEIGHT_EN
  logic [3:0] weight_p0;
  logic [3:0] weight_p1;

  popcnt15 u_popcnt (
    .din (fold_data),
    .cnt (weight_p0)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      weight_p1 <= '0;
    end else if (capture) begin
      weight_p1 <= weight_p0;
    end
  end

  assign out_weight = weight_p1;
`else
  assign out_weight = 4'd0;
`endif

  // State register, frame hold, and result capture stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      fold_clr     <= 1'b1;
      fold_data_in <= '0;
      out_result   <= '0;
      out_zero     <= 1'b1;
    end else begin
      state    <= state_nx;
      fold_clr <= (state_nx == CLEAR);
      if (accept) begin
        fold_data_in <= in_data;
      end
      if (capture) begin
        out_result <= fold_data;
        out_zero   <= is_zero(fold_data);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    fold_shift = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        state_nx = SHIFT;
      end
      SHIFT: begin
        fold_shift = !cnt_done;
        if (cnt_done) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fold_seq.sv
// Directed bench for fold_seq with a behavioural rotate-and-fold register attached.
module tb_fold_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] fold_data_in;
  logic        fold_clr;
  logic        fold_shift;
  logic [10:0] fold_count;
  logic [14:0] fold_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_result;
  logic        out_zero;
  logic [3:0]  out_weight;

  int total = 0;
  int bad   = 0;

  fold_seq #(.N(64), .K(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .fold_data_in (fold_data_in),
    .fold_clr     (fold_clr),
    .fold_shift   (fold_shift),
    .fold_count   (fold_count),
    .fold_data    (fold_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_weight   (out_weight)
  );

  always #5 clk = ~clk;

  // Fold register: rotate right, XOR the next frame bit (MSB first, then zeros) into bit 14.
  logic fr_bit;
  always_comb begin
    fr_bit = 1'b0;
    if (fold_count < 11'd64) fr_bit = fold_data_in[6'(11'd63 - fold_count)];
  end

  always @(posedge clk or posedge fold_clr) begin
    if (fold_clr) begin
      fold_data  <= '0;
      fold_count <= '0;
    end else if (fold_shift) begin
      fold_data  <= {fold_data[0], fold_data[14:1]} ^ {fr_bit, 14'b0};
      fold_count <= fold_count + 11'd1;
    end
  end

  function automatic logic [3:0] exp_w(input logic [3:0] w);
`ifdef FOLD_SEQ_WEIGHT_EN
    return w;
`else
    return 4'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [63:0] d);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_latch"}, fold_data_in, d);
    chk({tag, "_clr"}, 64'(fold_clr), 64'd1);
  endtask

  task automatic finish_frame(input string tag, input logic [14:0] res, input logic [3:0] w);
    int n = 0;
    int nshift = 0;
    int nclr = 1;
    while (!out_valid && n < 400) begin
      tick();
      n++;
      if (fold_shift) nshift++;
      if (fold_clr) nclr++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd106);
    chk({tag, "_shift_cycles"}, 64'(nshift), 64'd104);
    chk({tag, "_clr_cycles"}, 64'(nclr), 64'd1);
    chk({tag, "_result"}, 64'(out_result), 64'(res));
    chk({tag, "_zero"}, 64'(out_zero), 64'(res == 15'd0));
    chk({tag, "_weight"}, 64'(out_weight), 64'(exp_w(w)));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_clr", 64'(fold_clr), 64'd1);
    chk("rst_shift", 64'(fold_shift), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd1);
    chk("rst_weight", 64'(out_weight), 64'd0);
    chk("rst_data_in", fold_data_in, 64'd0);
    rst = 1'b1;
    tick();
    chk("rel_clr", 64'(fold_clr), 64'd0);
    chk("rel_ready", 64'(in_ready), 64'd1);

    accept("zero", 64'h0);
    finish_frame("zero", 15'h0000, 4'd0);
    release_out("zero");

    accept("msb", 64'h8000_0000_0000_0000);
    finish_frame("msb", 15'h0002, 4'd1);
    release_out("msb");

    accept("lsb", 64'h0000_0000_0000_0001);
    finish_frame("lsb", 15'h0010, 4'd1);
    release_out("lsb");

    accept("both", 64'h8000_0000_0000_0001);
    finish_frame("both", 15'h0012, 4'd2);
    release_out("both");

    accept("ones", 64'hFFFF_FFFF_FFFF_FFFF);
    finish_frame("ones", 15'h001E, 4'd4);
    release_out("ones");

    // Backpressure: result must hold while a new frame is offered
    accept("bp_a", 64'h8000_0000_0000_0001);
    finish_frame("bp_a", 15'h0012, 4'd2);
    in_valid = 1'b1;
    in_data  = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'h12);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_data_in", fold_data_in, 64'h8000_0000_0000_0001);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_valid", 64'(out_valid), 64'd0);
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    chk("bp_rel_data_in", fold_data_in, 64'h8000_0000_0000_0001);
    tick();
    in_valid = 1'b0;
    chk("bp_b_latch", fold_data_in, 64'h8000_0000_0000_0000);
    chk("bp_b_clr", 64'(fold_clr), 64'd1);
    finish_frame("bp_b", 15'h0002, 4'd1);
    release_out("bp_b");

    // Reset in the middle of shifting
    accept("mid", 64'hFFFF_0000_FFFF_0000);
    begin
      int n = 0;
      while (fold_count != 11'd50 && n < 200) begin tick(); n++; end
      chk("mid_reach50", 64'(fold_count), 64'd50);
    end
    rst = 1'b0;
    tick();
    chk("mid_rst_clr", 64'(fold_clr), 64'd1);
    chk("mid_rst_shift", 64'(fold_shift), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data_in", fold_data_in, 64'd0);
    chk("mid_rst_zero", 64'(out_zero), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rel_clr", 64'(fold_clr), 64'd0);
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    accept("after", 64'h0000_0000_0000_0001);
    finish_frame("after", 15'h0010, 4'd1);
    release_out("after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
